l15_req_arbiter: RTL
====================

// Module: l15_req_arbiter
// PURPOSE
// Shares the single L1.5 request/return port of a tile between NumReq requesters
// (core cache subsystem plus auxiliary masters such as a debug or accelerator port).
// Round-robin arbitration; the grant is locked from request issue until header ack.
// Tracks outstanding transactions per requester and routes each return to its owner
// using a source-ID field that the arbiter inserts into every issued request.
// PARAMETERS
// NumReq          2    number of requesters (>=2)
// ReqWidth        128  flattened request payload width
// RtrnWidth       256  flattened return payload width
// SrcIdLsb        0    LSB of the SrcW-bit source-ID field that the arbiter overwrites in the payload
// MaxOutstanding  4    max in-flight transactions per requester (>=1)
// PORTS
// clk_i            in   1                 clock
// reset_l          in   1                 async active-low reset
// req_val_i        in   NumReq            request valid per requester; held until req_ack_o
// req_data_i       in   NumReq*ReqWidth   request payloads
// req_ack_o        out  NumReq            one-hot header ack to the winning requester
// l15_val_o        out  1                 request valid to L1.5
// l15_data_o       out  ReqWidth          granted payload, source-ID field replaced
// l15_header_ack_i in   1                 L1.5 accepts current request
// l15_rtrn_val_i   in   1                 return beat valid
// l15_rtrn_data_i  in   RtrnWidth         return payload
// l15_rtrn_src_i   in   SrcW              source ID echoed by L1.5 (SrcW=$clog2(NumReq))
// rtrn_val_o       out  NumReq            one-hot return valid to owner
// rtrn_data_o      out  RtrnWidth         return payload broadcast to all requesters
// busy_o           out  NumReq            requester has >=1 outstanding transaction
// err_o            out  1                 sticky protocol error
// BEHAVIOUR
// - Clock clk_i; reset reset_l is asynchronous and active-low. Async assert, sync deassert handled upstream.
// - Reset values: l15_val_o=0, l15_data_o=0, req_ack_o=0, rtrn_val_o=0, busy_o=0, err_o=0.
//   RR pointer=0; all outstanding counters=0; FSM=IDLE.
// - Eligible(i) = req_val_i[i] && cnt[i] < MaxOutstanding.
// - FSM IDLE:
//   - If any requester is eligible, register the winner: the first eligible at or after the RR pointer,
//     wrapping modulo NumReq.
//   - Next cycle: l15_val_o=1 and l15_data_o = req_data_i[gnt] with bits
//     [SrcIdLsb+:SrcW] = gnt. Go to ISSUE.
//   - Arbitration latency: 1 cycle from req_val_i to l15_val_o.
// - FSM ISSUE:
//   - l15_val_o stays high and the grant is locked. l15_data_o tracks req_data_i[gnt]
//     combinationally, with the field overwritten.
//   - On l15_header_ack_i: req_ack_o[gnt]=1 in the same cycle (combinational), cnt[gnt]++,
//     RR pointer=(gnt+1)%NumReq, go to IDLE. l15_val_o drops the next cycle.
//   - Throughput: at most one request every 2 cycles.
// - header_ack while in IDLE: ignored, err_o set.
// - Requester withdraws req_val_i while in ISSUE: the request is still issued (protocol violation).
//   err_o is set.
// - Returns: rtrn_val_o[l15_rtrn_src_i] = l15_rtrn_val_i and rtrn_data_o = l15_rtrn_data_i,
//   both combinational with 0 latency. cnt[src]-- on each return beat; every request gets exactly one return.
// - Simultaneous header ack and return for the same requester: cnt unchanged.
// - Return for a requester with cnt=0: no decrement (saturates at 0), no rtrn_val_o, err_o set.
// - l15_rtrn_src_i >= NumReq: dropped, err_o set.
// - Counter width: $clog2(MaxOutstanding+1). cnt never exceeds MaxOutstanding, because eligibility
//   gates new grants. busy_o[i] = (cnt[i] != 0).
// - err_o clears only on reset.
// - reset_l asserted mid-transaction: all state is cleared immediately. In-flight returns arriving
//   after reset are treated as cnt=0 returns.
// TESTING
// - T1: req_val_i=2'b01 at cycle 0 -> l15_val_o=1 at cycle 1 with src field=0; header_ack at cycle 3
//   -> req_ack_o=2'b01 that cycle, busy_o=2'b01.
// - T2: req_val_i=2'b11 held, instant acks -> grants alternate 0,1,0,1; each requester is acked every 4 cycles.
// - T3: requester 0 issues 4 requests with no returns (MaxOutstanding=4) -> 5th request not granted
//   while requester 1 still is; one return with src=0 -> requester 0 regranted within 2 cycles.
// - T4: header_ack for requester 1 in the same cycle as a return with src=1 (cnt=2) -> cnt stays 2,
//   rtrn_val_o=2'b10.
// - T5: return with src=1 while cnt[1]=0 -> rtrn_val_o=0, err_o=1 and stays 1 until reset.
// - T6: assert reset_l low while in ISSUE -> l15_val_o=0, busy_o=0, RR pointer=0 immediately;
//   after release, req_val_i=2'b10 -> requester 1 is granted normally.

Source files
------------

// File: rtl/l15_req_arbiter.sv
// Round-robin arbiter sharing one L1.5 request/return port between NumReq requesters.
// Inserts a source ID into each request and steers returns back to their owner.
module l15_req_arbiter #(
  parameter int NumReq         = 2,
  parameter int ReqWidth       = 128,
  parameter int RtrnWidth      = 256,
  parameter int SrcIdLsb       = 0,
  parameter int MaxOutstanding = 4,
  localparam int SrcW          = $clog2(NumReq),
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_l,
  input  logic [NumReq-1:0]          req_val_i,
  input  logic [NumReq*ReqWidth-1:0] req_data_i,
  output logic [NumReq-1:0]          req_ack_o,
  output logic                       l15_val_o,
  output logic [ReqWidth-1:0]        l15_data_o,
  input  logic                       l15_header_ack_i,
  input  logic                       l15_rtrn_val_i,
  input  logic [RtrnWidth-1:0]       l15_rtrn_data_i,
  input  logic [SrcW-1:0]            l15_rtrn_src_i,
  output logic [NumReq-1:0]          rtrn_val_o,
  output logic [RtrnWidth-1:0]       rtrn_data_o,
  output logic [NumReq-1:0]          busy_o,
  output logic                       err_o
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [SrcW-1:0]     ptr_r, gnt_r, win_s, ptr_next_s;
  logic [CntW-1:0]     cnt_r [NumReq];
  logic [CntW-1:0]     cnt_s [NumReq];
  logic [NumReq-1:0]   elig_s;
  logic                any_elig_s, ack_fire_s, src_ok_s, rtrn_hit_s, err_set_s, err_r;

  assign ack_fire_s = (state_r == ISSUE) && l15_header_ack_i;
  assign src_ok_s   = int'(l15_rtrn_src_i) < NumReq;
  assign rtrn_hit_s = l15_rtrn_val_i && src_ok_s && (cnt_r[l15_rtrn_src_i] != CntW'(0));
  assign ptr_next_s = (gnt_r == SrcW'(NumReq - 1)) ? SrcW'(0) : gnt_r + SrcW'(1);
  assign err_o      = err_r;

  // Eligibility and round-robin winner search starting at the pointer
  always_comb begin
    int idx;
    win_s      = '0;
    any_elig_s = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      elig_s[i] = req_val_i[i] && (cnt_r[i] < CntW'(MaxOutstanding));
    end
    // Descending scan so the smallest offset from the pointer is assigned last
    for (int k = NumReq - 1; k >= 0; k--) begin
      idx = (int'(ptr_r) + k) % NumReq;
      if (elig_s[idx]) begin
        win_s      = SrcW'(idx);
        any_elig_s = 1'b1;
      end else begin
        win_s      = win_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // FSM next state
  always_comb begin
    case (state_r)
      IDLE:    state_s = any_elig_s ? ISSUE : IDLE;
      ISSUE:   state_s = l15_header_ack_i ? IDLE : ISSUE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: issue path, header ack, return steering, busy flags
  always_comb begin
    l15_val_o   = (state_r == ISSUE);
    l15_data_o  = '0;
    rtrn_data_o = l15_rtrn_data_i;
    if (state_r == ISSUE) begin
      l15_data_o                     = req_data_i[int'(gnt_r)*ReqWidth +: ReqWidth];
      l15_data_o[SrcIdLsb +: SrcW]   = gnt_r;
    end else begin
      l15_data_o = '0;
    end
    for (int i = 0; i < NumReq; i++) begin
      req_ack_o[i]  = ack_fire_s && (gnt_r == SrcW'(i));
      rtrn_val_o[i] = rtrn_hit_s && (l15_rtrn_src_i == SrcW'(i));
      busy_o[i]     = (cnt_r[i] != CntW'(0));
    end
  end

  // Outstanding counter next values and error detection
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      if (req_ack_o[i] && !rtrn_val_o[i])      cnt_s[i] = cnt_r[i] + CntW'(1);
      else if (!req_ack_o[i] && rtrn_val_o[i]) cnt_s[i] = cnt_r[i] - CntW'(1);
      else                                     cnt_s[i] = cnt_r[i];
    end
    err_set_s = ((state_r == IDLE) && l15_header_ack_i)
              || ((state_r == ISSUE) && !req_val_i[gnt_r])
              || (l15_rtrn_val_i && !rtrn_hit_s);
  end

  // Grant, pointer, counters and sticky error registers
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      gnt_r <= '0;
      ptr_r <= '0;
      err_r <= 1'b0;
      for (int i = 0; i < NumReq; i++) cnt_r[i] <= '0;
    end else begin
      if ((state_r == IDLE) && any_elig_s) gnt_r <= win_s;
      else                                 gnt_r <= gnt_r;
      if (ack_fire_s) ptr_r <= ptr_next_s;
      else            ptr_r <= ptr_r;
      err_r <= err_r | err_set_s;
      for (int i = 0; i < NumReq; i++) cnt_r[i] <= cnt_s[i];
    end
  end

endmodule
